// File: rtl/decode_stage_pipelined.sv
// Decode stage: instruction field decode, condition evaluation, register file
// with optional write-to-read bypass, and a stall/flush-capable output register.
module decode_stage_pipelined #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              hazard_in,
    input  logic [31:0]       instruction_in,
    input  logic [DATA_W-1:0] pc_plus_four_in,
    input  logic [3:0]        status_bits_in,
    input  logic              wb_en_in,
    input  logic [3:0]        wb_dest_in,
    input  logic [DATA_W-1:0] wb_value_in,
    output logic [3:0]        hazard_src1_out,
    output logic [3:0]        hazard_src2_out,
    output logic              hazard_two_src_out,
    output logic              has_src1_out,
    output logic              has_src2_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              branch_taken_out,
    output logic              do_update_sr_out,
    output logic [3:0]        execute_command_out,
    output logic [3:0]        wb_reg_dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [DATA_W-1:0] pc_plus_four_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] branch_immediate_out,
    output logic              is_immediate_out,
    output logic [11:0]       shifter_operand_out
);

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000, CMD_MVN = 4'b1001
    } cmd_e;

    typedef enum logic [1:0] {
        MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10, MODE_NONE = 2'b11
    } mode_e;

    localparam int         IDX_W   = $clog2(NUM_REGS);
    localparam logic [4:0] NREGS_5 = 5'(NUM_REGS);

    logic [3:0]  cond, opcode, rn, rd, rm, src2_idx;
    logic [1:0]  mode;
    logic        imm_bit, s_bit, is_str, cond_met;
    logic        n_f, z_f, c_f, v_f;
    logic [11:0] shifter;
    logic [23:0] imm24;

    assign cond    = instruction_in[31:28];
    assign mode    = instruction_in[27:26];
    assign imm_bit = instruction_in[25];
    assign opcode  = instruction_in[24:21];
    assign s_bit   = instruction_in[20];
    assign rn      = instruction_in[19:16];
    assign rd      = instruction_in[15:12];
    assign shifter = instruction_in[11:0];
    assign rm      = instruction_in[3:0];
    assign imm24   = instruction_in[23:0];
    assign {n_f, z_f, c_f, v_f} = status_bits_in;

    always_comb begin
        cond_met = 1'b0;
        case (cond)
            4'h0: cond_met = z_f;
            4'h1: cond_met = !z_f;
            4'h2: cond_met = c_f;
            4'h3: cond_met = !c_f;
            4'h4: cond_met = n_f;
            4'h5: cond_met = !n_f;
            4'h6: cond_met = v_f;
            4'h7: cond_met = !v_f;
            4'h8: cond_met = c_f && !z_f;
            4'h9: cond_met = !c_f || z_f;
            4'hA: cond_met = (n_f == v_f);
            4'hB: cond_met = (n_f != v_f);
            4'hC: cond_met = !z_f && (n_f == v_f);
            4'hD: cond_met = z_f || (n_f != v_f);
            4'hE: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    cmd_e cmd;
    logic wb, mem_r, mem_w, br, upd;

    always_comb begin
        cmd = CMD_NOP; wb = 1'b0; mem_r = 1'b0; mem_w = 1'b0; br = 1'b0; upd = 1'b0;
        case (mode_e'(mode))
            MODE_ALU: begin
                upd = s_bit;
                case (opcode)
                    4'b1101: begin cmd = CMD_MOV; wb = 1'b1; end
                    4'b1111: begin cmd = CMD_MVN; wb = 1'b1; end
                    4'b0100: begin cmd = CMD_ADD; wb = 1'b1; end
                    4'b0101: begin cmd = CMD_ADC; wb = 1'b1; end
                    4'b0010: begin cmd = CMD_SUB; wb = 1'b1; end
                    4'b0110: begin cmd = CMD_SBC; wb = 1'b1; end
                    4'b0000: begin cmd = CMD_AND; wb = 1'b1; end
                    4'b1100: begin cmd = CMD_ORR; wb = 1'b1; end
                    4'b0001: begin cmd = CMD_EOR; wb = 1'b1; end
                    4'b1010: cmd = CMD_SUB;
                    4'b1000: cmd = CMD_AND;
                    default: begin cmd = CMD_NOP; upd = 1'b0; end
                endcase
            end
            MODE_MEM: begin
                cmd = CMD_ADD;
                if (s_bit) begin mem_r = 1'b1; wb = 1'b1; end
                else       mem_w = 1'b1;
            end
            MODE_BR: br = 1'b1;
            default: ;
        endcase
        if (!cond_met || hazard_in) begin
            cmd = CMD_NOP; wb = 1'b0; mem_r = 1'b0; mem_w = 1'b0; br = 1'b0; upd = 1'b0;
        end
    end

    // Source bookkeeping is taken from the raw encoding so hazard detection sees it even when squashed.
    assign is_str             = (mode == MODE_MEM) && !s_bit;
    assign src2_idx           = is_str ? rd : rm;
    assign hazard_src1_out    = rn;
    assign hazard_src2_out    = src2_idx;
    assign hazard_two_src_out = !imm_bit || is_str;
    assign has_src1_out       = !((mode == MODE_ALU && (opcode == 4'b1101 || opcode == 4'b1111))
                                  || mode == MODE_BR || mode == MODE_NONE);
    assign has_src2_out       = (mode == MODE_ALU && !imm_bit) || is_str;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wb_valid;
    assign wb_valid = wb_en_in && ({1'b0, wb_dest_in} < NREGS_5);

    always_ff @(posedge clk) begin
        if (rst)           regs <= '{default: '0};
        else if (wb_valid) regs[wb_dest_in[IDX_W-1:0]] <= wb_value_in;
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] idx);
        if ({1'b0, idx} >= NREGS_5)                        return '0;
        if (WB_BYPASS != 0 && wb_valid && wb_dest_in == idx) return wb_value_in;
        return regs[idx[IDX_W-1:0]];
    endfunction

    logic [DATA_W-1:0] rn_val, rm_val;
    always_comb rn_val = read_reg(rn);
    always_comb rm_val = read_reg(src2_idx);

    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            wb_en_out <= 1'b0; mem_r_en_out <= 1'b0; mem_w_en_out <= 1'b0;
            branch_taken_out <= 1'b0; do_update_sr_out <= 1'b0;
            execute_command_out <= '0; wb_reg_dest_out <= '0;
            src1_out <= '0; src2_out <= '0;
            pc_plus_four_out <= '0; val_rn_out <= '0; val_rm_out <= '0;
            branch_immediate_out <= '0; is_immediate_out <= 1'b0; shifter_operand_out <= '0;
        end else if (!stall_in) begin
            wb_en_out <= wb; mem_r_en_out <= mem_r; mem_w_en_out <= mem_w;
            branch_taken_out <= br; do_update_sr_out <= upd;
            execute_command_out <= cmd; wb_reg_dest_out <= rd;
            src1_out <= rn; src2_out <= src2_idx;
            pc_plus_four_out <= pc_plus_four_in; val_rn_out <= rn_val; val_rm_out <= rm_val;
            branch_immediate_out <= {{(DATA_W-24){imm24[23]}}, imm24};
            is_immediate_out <= imm_bit; shifter_operand_out <= shifter;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: three instances (default, no bypass, 8 registers)
// share stimulus; expected registered outputs are queued per cycle and checked after the edge.
module tb_decode_stage_pipelined;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, flush, hazard, wb_en;
    logic [31:0]   instr;
    logic [W-1:0]  pc, wb_val;
    logic [3:0]    status, wb_dest;

    logic [3:0]    hs1_o [3], hs2_o [3], cmd_o [3], rd_o [3], s1_o [3], s2_o [3];
    logic          two_o [3], h1_o [3], h2_o [3], wb_o [3], mr_o [3], mw_o [3];
    logic          br_o [3], upd_o [3], imm_o [3];
    logic [W-1:0]  pc_o [3], vrn_o [3], vrm_o [3], bimm_o [3];
    logic [11:0]   shop_o [3];

    `define DUT_PORTS(k) \
        .clk(clk), .rst(rst), .stall_in(stall), .flush_in(flush), .hazard_in(hazard), \
        .instruction_in(instr), .pc_plus_four_in(pc), .status_bits_in(status), \
        .wb_en_in(wb_en), .wb_dest_in(wb_dest), .wb_value_in(wb_val), \
        .hazard_src1_out(hs1_o[k]), .hazard_src2_out(hs2_o[k]), .hazard_two_src_out(two_o[k]), \
        .has_src1_out(h1_o[k]), .has_src2_out(h2_o[k]), .wb_en_out(wb_o[k]), \
        .mem_r_en_out(mr_o[k]), .mem_w_en_out(mw_o[k]), .branch_taken_out(br_o[k]), \
        .do_update_sr_out(upd_o[k]), .execute_command_out(cmd_o[k]), .wb_reg_dest_out(rd_o[k]), \
        .src1_out(s1_o[k]), .src2_out(s2_o[k]), .pc_plus_four_out(pc_o[k]), \
        .val_rn_out(vrn_o[k]), .val_rm_out(vrm_o[k]), .branch_immediate_out(bimm_o[k]), \
        .is_immediate_out(imm_o[k]), .shifter_operand_out(shop_o[k])

    decode_stage_pipelined #(.DATA_W(W), .NUM_REGS(16), .WB_BYPASS(1)) u_def   (`DUT_PORTS(0));
    decode_stage_pipelined #(.DATA_W(W), .NUM_REGS(16), .WB_BYPASS(0)) u_nobyp (`DUT_PORTS(1));
    decode_stage_pipelined #(.DATA_W(W), .NUM_REGS(8),  .WB_BYPASS(1)) u_small (`DUT_PORTS(2));

    typedef enum int {F_WB, F_MR, F_MW, F_BR, F_UPD, F_CMD, F_RD, F_S1, F_S2, F_PC,
                      F_VRN, F_VRM, F_BIMM, F_IMM, F_SHOP, F_CTRL} field_e;
    typedef struct { string tag; int dut; field_e f; logic [63:0] v; } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] obs(int k, field_e f);
        case (f)
            F_WB:   return 64'(wb_o[k]);
            F_MR:   return 64'(mr_o[k]);
            F_MW:   return 64'(mw_o[k]);
            F_BR:   return 64'(br_o[k]);
            F_UPD:  return 64'(upd_o[k]);
            F_CMD:  return 64'(cmd_o[k]);
            F_RD:   return 64'(rd_o[k]);
            F_S1:   return 64'(s1_o[k]);
            F_S2:   return 64'(s2_o[k]);
            F_PC:   return 64'(pc_o[k]);
            F_VRN:  return 64'(vrn_o[k]);
            F_VRM:  return 64'(vrm_o[k]);
            F_BIMM: return 64'(bimm_o[k]);
            F_IMM:  return 64'(imm_o[k]);
            F_SHOP: return 64'(shop_o[k]);
            default: return 64'({wb_o[k], mr_o[k], mw_o[k], br_o[k], upd_o[k], cmd_o[k]});
        endcase
    endfunction

    task automatic expect_reg(input string tag, input int k, input field_e f, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.dut = k; e.f = f; e.v = v;
        q.push_back(e);
    endtask

    // Advance one edge and retire every expectation queued for it.
    task automatic step();
        exp_t e;
        logic [63:0] o;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.dut, e.f);
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] v);
        total++;
        assert (o === v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, v);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [W-1:0] p);
        instr = i; pc = p;
    endtask

    task automatic write_port(input logic en, input logic [3:0] d, input logic [W-1:0] v);
        wb_en = en; wb_dest = d; wb_val = v;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; hazard = 1'b0; status = 4'b0000;
        drive(32'hE0823001, 32'h104);
        write_port(1'b0, 4'd0, '0);

        expect_reg("rst_ctrl", 0, F_CTRL, 0);
        expect_reg("rst_pc", 0, F_PC, 0);
        expect_reg("rst_rd", 0, F_RD, 0);
        expect_reg("rst_bimm", 0, F_BIMM, 0);
        step();

        rst = 1'b0;
        drive(32'h0, 32'h0);
        write_port(1'b1, 4'd3, 32'h5);
        step();
        write_port(1'b1, 4'd2, 32'h7);
        step();

        // ADD R3, R2, R1
        write_port(1'b0, 4'd0, '0);
        drive(32'hE0823001, 32'h104);
        #1;
        chk("add_hsrc1", 64'(hs1_o[0]), 2);
        chk("add_hsrc2", 64'(hs2_o[0]), 1);
        chk("add_flags", 64'({two_o[0], h1_o[0], h2_o[0]}), 3'b111);
        expect_reg("add_cmd", 0, F_CMD, 4'b0010);
        expect_reg("add_wb", 0, F_WB, 1);
        expect_reg("add_vrn", 0, F_VRN, 7);
        expect_reg("add_vrm", 0, F_VRM, 0);
        expect_reg("add_rd", 0, F_RD, 3);
        expect_reg("add_pc", 0, F_PC, 32'h104);
        expect_reg("add_vrn_small", 2, F_VRN, 7);
        step();

        // same-cycle write to the register being read
        write_port(1'b1, 4'd2, 32'hAA);
        expect_reg("byp_vrn_on", 0, F_VRN, 32'hAA);
        expect_reg("byp_vrn_off", 1, F_VRN, 7);
        step();
        write_port(1'b0, 4'd0, '0);
        expect_reg("after_byp_off", 1, F_VRN, 32'hAA);
        step();

        // BEQ, Z clear then set
        drive(32'h0A000010, 32'h300);
        #1;
        chk("beq_has_src1", 64'(h1_o[0]), 0);
        expect_reg("beq_z0_br", 0, F_BR, 0);
        expect_reg("beq_z0_ctrl", 0, F_CTRL, 0);
        step();
        status = 4'b0100;
        expect_reg("beq_z1_br", 0, F_BR, 1);
        expect_reg("beq_z1_bimm", 0, F_BIMM, 32'h10);
        step();
        drive(32'hEAFFFFFE, 32'h304);
        expect_reg("b_neg_bimm", 0, F_BIMM, 32'hFFFFFFFE);
        expect_reg("b_neg_br", 0, F_BR, 1);
        step();
        status = 4'b0000;

        // STR R2, [R1]
        drive(32'hE5812000, 32'h308);
        #1;
        chk("str_hsrc2", 64'(hs2_o[0]), 2);
        chk("str_two_src", 64'(two_o[0]), 1);
        expect_reg("str_mw", 0, F_MW, 1);
        expect_reg("str_wb", 0, F_WB, 0);
        expect_reg("str_cmd", 0, F_CMD, 4'b0010);
        expect_reg("str_src2", 0, F_S2, 2);
        expect_reg("str_vrm", 0, F_VRM, 32'hAA);
        step();
        hazard = 1'b1;
        #1;
        chk("haz_has_src2", 64'(h2_o[0]), 1);
        expect_reg("haz_ctrl", 0, F_CTRL, 0);
        expect_reg("haz_src2", 0, F_S2, 2);
        step();
        hazard = 1'b0;

        // LDR, CMP with S, MOV immediate
        drive(32'hE5912000, 32'h30C);
        expect_reg("ldr_mr", 0, F_MR, 1);
        expect_reg("ldr_wb", 0, F_WB, 1);
        step();
        drive(32'hE1520003, 32'h310);
        expect_reg("cmp_cmd", 0, F_CMD, 4'b0100);
        expect_reg("cmp_wb", 0, F_WB, 0);
        expect_reg("cmp_upd", 0, F_UPD, 1);
        step();
        drive(32'hE3A01005, 32'h314);
        #1;
        chk("mov_flags", 64'({two_o[0], h1_o[0], h2_o[0]}), 3'b000);
        expect_reg("mov_cmd", 0, F_CMD, 4'b0001);
        expect_reg("mov_imm", 0, F_IMM, 1);
        expect_reg("mov_shop", 0, F_SHOP, 12'h005);
        step();

        // stall holds across changing inputs
        drive(32'hE0823001, 32'h200);
        expect_reg("pre_stall_pc", 0, F_PC, 32'h200);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hE3A01005 + 32'(i), 32'h400 + 32'(4 * i));
            expect_reg("stall_cmd", 0, F_CMD, 4'b0010);
            expect_reg("stall_wb", 0, F_WB, 1);
            expect_reg("stall_pc", 0, F_PC, 32'h200);
            expect_reg("stall_rd", 0, F_RD, 3);
            step();
        end
        flush = 1'b1;
        expect_reg("flush_ctrl", 0, F_CTRL, 0);
        expect_reg("flush_pc", 0, F_PC, 0);
        expect_reg("flush_vrn", 0, F_VRN, 0);
        step();
        flush = 1'b0; stall = 1'b0;
        drive(32'hE0823001, 32'h500);
        expect_reg("reload_cmd", 0, F_CMD, 4'b0010);
        step();
        stall = 1'b1; rst = 1'b1;
        expect_reg("rst_stall_ctrl", 0, F_CTRL, 0);
        expect_reg("rst_stall_pc", 0, F_PC, 0);
        expect_reg("rst_stall_rd", 0, F_RD, 0);
        step();
        stall = 1'b0; rst = 1'b0;
        expect_reg("rst_cleared_r2", 0, F_VRN, 0);
        expect_reg("rst_cleared_cmd", 0, F_CMD, 4'b0010);
        step();

        // out-of-range index on the 8-register instance
        drive(32'hE08C3001, 32'h600);
        write_port(1'b1, 4'd12, 32'h55);
        expect_reg("r12_small_byp", 2, F_VRN, 0);
        expect_reg("r12_big_byp", 0, F_VRN, 32'h55);
        step();
        write_port(1'b0, 4'd0, '0);
        expect_reg("r12_small_read", 2, F_VRN, 0);
        expect_reg("r12_big_read", 0, F_VRN, 32'h55);
        step();
        drive(32'hE0843001, 32'h604);
        expect_reg("r4_small_untouched", 2, F_VRN, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
